commit_unit: RTL
================

# commit_unit

In-order retirement stage of the out-of-order core; the consumer end of the instruction buffer that dispatch fills. Each cycle it locates the oldest entries by tag and retires up to two that have executed and are non-speculative. Retirement writes results to the register file, performs stores to data memory through a valid/ready handshake, and returns buffer slots to S_NOT_USED.

## Interface
Parameters:
- BUF_SIZE, package constant (8), number of buffer entries; must be ≤ 16 (tag space)

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous, active-low reset
- entries_all  in  entry_t[BUF_SIZE]  current buffer contents
- reg_we  out  1[2]  register write enable, slot 0/1
- reg_waddr  out  5[2]  write address (Dest)
- reg_wdata  out  32[2]  write data (entry result)
- free_valid  out  1[2]  release entry; buffer owner sets e_state=S_NOT_USED at next edge
- free_index  out  index_t[2]  entry to release
- mem_req_valid  out  1  store request
- mem_req_ready  in  1  memory accepts store
- mem_addr  out  32  store address (entry result)
- mem_wdata  out  32  store data (entry Vk)
- mem_rwmm  out  rwmm_t  store width/mode (entry rwmm)
- store_retired  out  1  one-cycle pulse; every entry decrements number_of_early_store_ops
- commit_tag  out  tag_t  current next_tag

## Operation
- next_tag: 4-bit register, oldest tag not yet retired.
- Slot 0 candidate: used entry (e_state != S_NOT_USED) with tag == next_tag; slot 1: tag == next_tag+1 mod 16. Missing candidate = not retireable.
- retireable(e): e_state == S_EXECUTED and (speculative_tag & ~specific_speculative_tag) == 0.
- Slot 1 retires only if slot 0 retires the same cycle and slot 1 is not STORE.
- Register write: retiring non-STORE entry with Dest != 0 → reg_we=1, reg_waddr=Dest, reg_wdata=result. Dest==0 → no write, entry still freed.
- Same Dest in both slots: both writes issued; slot 1 has priority at the register file.
- FSM states: S_IDLE, S_STORE.
  - S_IDLE: slot 0 retireable STORE → latch index, result, Vk, rwmm; go S_STORE; nothing retires this cycle. Otherwise retire per rules; next_tag += count (0/1/2) mod 16.
  - S_STORE: mem_req_valid=1 with latched values; no other retirement. On valid&&ready: free_valid[0]=1 (latched index), store_retired=1, next_tag += 1, go S_IDLE.
- Empty buffer (no used entries in entries_all): next_tag <= 0 (matches dispatch restarting tags at 0); overrides increment.
- A non-speculative latched store is never flushed; the latched entry stays valid until freed.

## Timing
- Reset (async, rst_n low): next_tag=0, state=S_IDLE, latches cleared; reg_we, free_valid, mem_req_valid, store_retired all 0; commit_tag=0.
- Non-store retirement: reg_*/free_* combinational from entries_all and next_tag in the same cycle; next_tag updates at the edge. Throughput 2/cycle.
- Store: ≥2 cycles (latch cycle + handshake cycle). mem_addr/mem_wdata/mem_rwmm stable while mem_req_valid=1; valid never drops before ready.
- Tag wrap: 15 → 0; slot 1 of next_tag=15 is tag 0.
- Reset mid-store: request dropped immediately; memory must ignore it.

## Structure
- Shared package: BUF_SIZE, tag_t, index_t, spectag_t, entry_t, unit and e_state enums, rwmm_t, new commit_state_t {S_IDLE, S_STORE}.
- Sub-module commit_finder: combinational tag search over entries_all; returns found/index/entry for next_tag and next_tag+1, plus any_used flag.

## Test plan
- tag0 ALU Dest=5 result=0x11 at idx3, tag1 Dest=6 result=0x22 at idx1, both EXECUTED → same cycle: reg writes (5,0x11),(6,0x22), free 3 and 1; next_tag=2.
- tag0 NOT_EXECUTED, tag1 EXECUTED → no retirement, no writes; tag0 executes → both retire that cycle.
- tag0 STORE result=0x100 Vk=0xDEAD, ready low 3 cycles → cycle 1 nothing, then mem_req_valid=1 with stable 0x100/0xDEAD; ready high → free, store_retired pulse, next_tag=1.
- next_tag=15, tags 15 and 0 EXECUTED → both retire; next_tag=1.
- tag0 EXECUTED, speculative_tag=6'b000010, specific=0 → held; speculative bit cleared → retires next cycle.
- Retire last entry (next_tag 7→8), buffer empty next cycle → next_tag=0; rst_n low during S_STORE → mem_req_valid=0 immediately, state S_IDLE.

Source files
------------

// File: rtl/commit_unit_pkg.sv
// Shared types for the retirement stage: buffer entry layout, tag/index widths
// and the commit FSM state encoding.
package commit_unit_pkg;

  localparam int BUF_SIZE = 8;
  localparam int TAG_W    = 4;
  localparam int IDX_W    = $clog2(BUF_SIZE);

  typedef logic [TAG_W-1:0] tag_t;
  typedef logic [IDX_W-1:0] index_t;
  typedef logic [5:0]       spectag_t;
  typedef logic [2:0]       rwmm_t;

  typedef enum logic [1:0] {
    S_NOT_USED  = 2'd0,
    S_WAITING   = 2'd1,
    S_EXECUTING = 2'd2,
    S_EXECUTED  = 2'd3
  } e_state_t;

  typedef enum logic [2:0] {
    U_ALU    = 3'd0,
    U_MUL    = 3'd1,
    U_BRANCH = 3'd2,
    U_LOAD   = 3'd3,
    U_STORE  = 3'd4
  } unit_t;

  typedef struct packed {
    e_state_t    e_state;
    unit_t       unit;
    tag_t        tag;
    logic [4:0]  dest;
    logic [31:0] vk;
    logic [31:0] result;
    rwmm_t       rwmm;
    spectag_t    speculative_tag;
    spectag_t    specific_speculative_tag;
  } entry_t;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_STORE = 1'b1
  } commit_state_t;

  // Executed and not shadowed by any unresolved branch other than its own.
  function automatic logic retireable(input entry_t e);
    return (e.e_state == S_EXECUTED) &&
           ((e.speculative_tag & ~e.specific_speculative_tag) == '0);
  endfunction

endpackage

// File: rtl/commit_unit_finder.sv
// Combinational tag search: locates the used entries holding two given tags.
module commit_unit_finder
  import commit_unit_pkg::*;
(
  input  entry_t entries_all [BUF_SIZE],
  input  tag_t   tag0,
  output logic   found0,
  output index_t index0,
  output entry_t entry0,
  output logic   found1,
  output index_t index1,
  output entry_t entry1,
  output logic   any_used
);

  tag_t tag1;
  assign tag1 = tag0 + tag_t'(1);

  // Tags are unique among used entries; lowest index wins if that ever breaks.
  always_comb begin
    found0   = 1'b0;
    index0   = '0;
    entry0   = '0;
    found1   = 1'b0;
    index1   = '0;
    entry1   = '0;
    any_used = 1'b0;
    for (int i = 0; i < BUF_SIZE; i++) begin
      if (entries_all[i].e_state != S_NOT_USED) begin
        any_used = 1'b1;
        if (!found0 && entries_all[i].tag == tag0) begin
          found0 = 1'b1;
          index0 = index_t'(i);
          entry0 = entries_all[i];
        end
        if (!found1 && entries_all[i].tag == tag1) begin
          found1 = 1'b1;
          index1 = index_t'(i);
          entry1 = entries_all[i];
        end
      end
    end
  end

endmodule

// File: rtl/commit_unit.sv
// In-order retirement: up to two register-writing entries per cycle, or one
// store through a valid/ready memory handshake.
module commit_unit
  import commit_unit_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  entry_t               entries_all [BUF_SIZE],
  output logic [1:0]           reg_we,
  output logic [1:0][4:0]      reg_waddr,
  output logic [1:0][31:0]     reg_wdata,
  output logic [1:0]           free_valid,
  output index_t [1:0]         free_index,
  output logic                 mem_req_valid,
  input  logic                 mem_req_ready,
  output logic [31:0]          mem_addr,
  output logic [31:0]          mem_wdata,
  output rwmm_t                mem_rwmm,
  output logic                 store_retired,
  output tag_t                 commit_tag,
  output commit_state_t        fsm_state
);

  // Memory handshake: mem_req_valid stays high with mem_addr/mem_wdata/mem_rwmm
  // frozen from the latched store until a cycle where mem_req_ready is also
  // high; that cycle completes the transfer and retires the store.

  commit_state_t state_q, state_d;
  tag_t          tag_q, tag_d;
  index_t        st_idx_q;
  logic [31:0]   st_addr_q, st_data_q;
  rwmm_t         st_rwmm_q;

  logic   found0, found1, any_used;
  index_t idx0, idx1;
  entry_t e0, e1;
  logic   ok0, ok1, start_store;

  commit_unit_finder u_finder (
    .entries_all (entries_all),
    .tag0        (tag_q),
    .found0      (found0),
    .index0      (idx0),
    .entry0      (e0),
    .found1      (found1),
    .index1      (idx1),
    .entry1      (e1),
    .any_used    (any_used)
  );

  logic unused_fields;
  assign unused_fields = ^{e0.tag, e1.tag, e1.vk, e1.rwmm};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      tag_q     <= '0;
      st_idx_q  <= '0;
      st_addr_q <= '0;
      st_data_q <= '0;
      st_rwmm_q <= '0;
    end else begin
      state_q <= state_d;
      tag_q   <= tag_d;
      if (start_store) begin
        st_idx_q  <= idx0;
        st_addr_q <= e0.result;
        st_data_q <= e0.vk;
        st_rwmm_q <= e0.rwmm;
      end
    end
  end

  always_comb begin
    reg_we        = '0;
    reg_waddr     = '0;
    reg_wdata     = '0;
    free_valid    = '0;
    free_index    = '0;
    mem_req_valid = 1'b0;
    store_retired = 1'b0;
    start_store   = 1'b0;
    state_d       = state_q;
    tag_d         = tag_q;
    ok0           = found0 && retireable(e0);
    ok1           = found1 && retireable(e1) && (e1.unit != U_STORE);
    if (rst_n) begin
      case (state_q)
        S_IDLE: begin
          if (ok0 && e0.unit == U_STORE) begin
            start_store = 1'b1;
            state_d     = S_STORE;
          end else if (ok0) begin
            free_valid[0] = 1'b1;
            free_index[0] = idx0;
            reg_we[0]     = (e0.dest != 5'd0);
            reg_waddr[0]  = e0.dest;
            reg_wdata[0]  = e0.result;
            tag_d         = tag_q + tag_t'(1);
            if (ok1) begin
              free_valid[1] = 1'b1;
              free_index[1] = idx1;
              reg_we[1]     = (e1.dest != 5'd0);
              reg_waddr[1]  = e1.dest;
              reg_wdata[1]  = e1.result;
              tag_d         = tag_q + tag_t'(2);
            end
          end
        end
        S_STORE: begin
          mem_req_valid = 1'b1;
          if (mem_req_ready) begin
            free_valid[0] = 1'b1;
            free_index[0] = st_idx_q;
            store_retired = 1'b1;
            tag_d         = tag_q + tag_t'(1);
            state_d       = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
      // Dispatch restarts tags at 0 once the buffer drains.
      if (!any_used) tag_d = '0;
    end
  end

  assign mem_addr   = st_addr_q;
  assign mem_wdata  = st_data_q;
  assign mem_rwmm   = st_rwmm_q;
  assign commit_tag = tag_q;
  assign fsm_state  = state_q;

endmodule
